alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_if.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction offer, per-beat ALU issue and write-back signals
// between an instruction source (master) and alu_issue_ctrl (slave).
interface alu_issue_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int MICROOP_BIT = 9,
  parameter int VL_BITS     = 8
);
  localparam int NB = DATA_WIDTH / 8;

  logic                   instr_valid;
  logic                   instr_ready;
  logic [MICROOP_BIT-1:0] instr_op;
  logic [2:0]             instr_sew;
  logic [VL_BITS-1:0]     instr_vl;
  logic                   instr_masked;
  logic                   issue_stall;
  logic [NB-1:0]          mask_slice;
  logic                   flush;

  logic                   alu_valid;
  logic [MICROOP_BIT-1:0] alu_op;
  logic [2:0]             alu_sew;
  logic [NB-1:0]          alu_mask_bits;
  logic                   alu_masked_result;
  logic [VL_BITS-1:0]     beat_idx;
  logic                   wb_valid;
  logic [VL_BITS-1:0]     wb_beat;
  logic                   busy;

  modport master (
    output instr_valid, instr_op, instr_sew, instr_vl, instr_masked,
           issue_stall, mask_slice, flush,
    input  instr_ready, alu_valid, alu_op, alu_sew, alu_mask_bits,
           alu_masked_result, beat_idx, wb_valid, wb_beat, busy
  );

  modport slave (
    input  instr_valid, instr_op, instr_sew, instr_vl, instr_masked,
           issue_stall, mask_slice, flush,
    output instr_ready, alu_valid, alu_op, alu_sew, alu_mask_bits,
           alu_masked_result, beat_idx, wb_valid, wb_beat, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: splits a vector instruction into ALU beats with tail/v0
// masking and routes multiply-class results through a fixed-latency pipe.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int MICROOP_BIT = 9,
  parameter int MUL_LATENCY = 2,
  parameter int VL_BITS     = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_issue_if.slave bus
);
  // state | meaning
  // IDLE  | ready for a new instruction
  // ISSUE | presenting beats to the ALU, one per unstalled cycle
  // DRAIN | waiting for multiply results still in the latency pipe

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LNB = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW  = VL_BITS + LNB + 1;
  localparam int SRD = (MUL_LATENCY > 0) ? MUL_LATENCY : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;
  state_t state_q, state_d;

  logic [MICROOP_BIT-1:0] op_q;
  logic [2:0]             sew_q;
  logic [VL_BITS-1:0]     vl_q;
  logic [VL_BITS-1:0]     beat_q;
  logic                   masked_q;
  logic                   mul_q;
  logic [LNB:0]           epb_q;
  logic [LNB:0]           epb_in;

  logic [SRD-1:0]         sr_valid_q;
  logic [SRD-1:0]         sr_valid_d;
  logic [VL_BITS-1:0]     sr_beat_q [SRD];

  logic          ready;
  logic          fire;
  logic          accept;
  logic          start_ok;
  logic          is_mul_in;
  logic          last_beat;
  logic          any_tail;
  logic [NB-1:0] mask_bits;
  logic [BW-1:0] base;
  logic          wv;
  logic [VL_BITS-1:0] wbb;

  assign epb_in    = (LNB+1)'(NB >> bus.instr_sew);
  assign is_mul_in = (bus.instr_op[5:3] == 3'b100) ||
                     (bus.instr_op[5:0] == 6'b101101) ||
                     (bus.instr_op[7:0] == 8'b10101001);
  // reserved sew and vl=0 are accepted but never leave IDLE
  assign start_ok  = (bus.instr_vl != '0) && !bus.instr_sew[2] && (epb_in != '0);
  assign accept    = bus.instr_valid && ready;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && start_ok) state_d = ISSUE;
      ISSUE:   if (fire && last_beat) state_d = mul_q ? DRAIN : IDLE;
      DRAIN:   if (sr_valid_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = !rst && !bus.flush && (state_q == IDLE);
    fire  = !rst && (state_q == ISSUE) && !bus.issue_stall;
    if (mul_q) begin
      wv  = !rst && sr_valid_q[SRD-1];
      wbb = sr_beat_q[SRD-1];
    end else begin
      wv  = fire;
      wbb = beat_q;
    end
    bus.instr_ready       = ready;
    bus.busy              = !rst && (state_q != IDLE);
    bus.alu_valid         = fire;
    bus.alu_op            = rst ? '0 : op_q;
    bus.alu_sew           = rst ? '0 : sew_q;
    bus.alu_mask_bits     = fire ? mask_bits : '0;
    bus.alu_masked_result = fire && (masked_q || any_tail);
    bus.beat_idx          = fire ? beat_q : '0;
    bus.wb_valid          = wv;
    bus.wb_beat           = wv ? wbb : '0;
  end

  // element base+i is live only while it lies below vl
  always_comb begin
    base      = BW'(beat_q) * BW'(epb_q);
    mask_bits = '0;
    any_tail  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (BW'(i) < BW'(epb_q)) begin
        if ((base + BW'(i)) < BW'(vl_q)) mask_bits[i] = bus.mask_slice[i] | ~masked_q;
        else                              any_tail     = 1'b1;
      end
    end
    last_beat = (base + BW'(epb_q)) >= BW'(vl_q);
  end

  always_comb begin
    sr_valid_d    = '0;
    sr_valid_d[0] = mul_q && fire;
    for (int k = 1; k < SRD; k++) sr_valid_d[k] = sr_valid_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      sew_q      <= '0;
      vl_q       <= '0;
      masked_q   <= 1'b0;
      mul_q      <= 1'b0;
      epb_q      <= '0;
      beat_q     <= '0;
      sr_valid_q <= '0;
      for (int k = 0; k < SRD; k++) sr_beat_q[k] <= '0;
    end else begin
      if (accept && start_ok) begin
        op_q     <= bus.instr_op;
        sew_q    <= bus.instr_sew;
        vl_q     <= bus.instr_vl;
        masked_q <= bus.instr_masked;
        mul_q    <= is_mul_in && (MUL_LATENCY > 0);
        epb_q    <= epb_in;
        beat_q   <= '0;
      end else if (bus.flush || (fire && last_beat)) begin
        beat_q <= '0;
      end else if (fire) begin
        beat_q <= beat_q + 1'b1;
      end

      // the pipe advances every cycle; only flush empties it
      if (bus.flush) begin
        sr_valid_q <= '0;
        for (int k = 0; k < SRD; k++) sr_beat_q[k] <= '0;
      end else begin
        sr_valid_q   <= sr_valid_d;
        sr_beat_q[0] <= beat_q;
        for (int k = 1; k < SRD; k++) sr_beat_q[k] <= sr_beat_q[k-1];
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed cycle-by-cycle vectors with hand-computed
// expectations for beat issue, masking, multiply latency, flush and reset.
module tb_alu_issue_ctrl;
  localparam int DW = 64;
  localparam int MB = 9;
  localparam int ML = 2;
  localparam int VB = 8;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  alu_issue_if #(.DATA_WIDTH(DW), .MICROOP_BIT(MB), .VL_BITS(VB)) bus ();

  alu_issue_ctrl #(
    .DATA_WIDTH(DW), .MICROOP_BIT(MB), .MUL_LATENCY(ML), .VL_BITS(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic av, input logic [7:0] bi,
                         input logic [7:0] mb, input logic mr, input logic wv,
                         input logic [7:0] wb, input logic rdy, input logic bsy);
    chk({tag, ".alu_valid"},   bus.alu_valid,         av);
    chk({tag, ".beat_idx"},    bus.beat_idx,          bi);
    chk({tag, ".mask_bits"},   bus.alu_mask_bits,     mb);
    chk({tag, ".masked_res"},  bus.alu_masked_result, mr);
    chk({tag, ".wb_valid"},    bus.wb_valid,          wv);
    chk({tag, ".wb_beat"},     bus.wb_beat,           wb);
    chk({tag, ".instr_ready"}, bus.instr_ready,       rdy);
    chk({tag, ".busy"},        bus.busy,              bsy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [8:0] op, input logic [2:0] sew,
                       input logic [7:0] vl, input logic m);
    bus.instr_valid  = 1'b1;
    bus.instr_op     = op;
    bus.instr_sew    = sew;
    bus.instr_vl     = vl;
    bus.instr_masked = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] mops [2];
    mops[0] = 9'b010101101;
    mops[1] = 9'b010101001;

    rst              = 1'b1;
    bus.instr_valid  = 1'b0;
    bus.instr_op     = '0;
    bus.instr_sew    = '0;
    bus.instr_vl     = '0;
    bus.instr_masked = 1'b0;
    bus.issue_stall  = 1'b0;
    bus.mask_slice   = '0;
    bus.flush        = 1'b0;

    // reset wins over an offered instruction
    tick(); offer(9'h000, 3'd0, 8'd20, 1'b0);
    @(negedge clk); chk_out("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.alu_op", bus.alu_op, 0);
    tick(); rst = 1'b0; bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("idle", 0, 0, 0, 0, 0, 0, 1, 0);

    // vadd sew=0 vl=20: three beats, last one tail-masked
    tick(); offer(9'h000, 3'd0, 8'd20, 1'b0);
    @(negedge clk); chk_out("vadd.acc", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("vadd.b0", 1, 0, 8'hFF, 0, 1, 0, 0, 1);
    tick(); @(negedge clk); chk_out("vadd.b1", 1, 1, 8'hFF, 0, 1, 1, 0, 1);
    tick(); @(negedge clk); chk_out("vadd.b2", 1, 2, 8'h0F, 1, 1, 2, 0, 1);
    tick(); @(negedge clk); chk_out("vadd.end", 0, 0, 0, 0, 0, 0, 1, 0);

    // vmul sew=2 vl=4: two beats, write-back two cycles later
    tick(); offer(9'b010100101, 3'd2, 8'd4, 1'b0);
    @(negedge clk); chk_out("vmul.acc", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("vmul.c0", 1, 0, 8'h03, 0, 0, 0, 0, 1);
    chk("vmul.alu_op", bus.alu_op, 9'b010100101);
    chk("vmul.alu_sew", bus.alu_sew, 2);
    tick(); @(negedge clk); chk_out("vmul.c1", 1, 1, 8'h03, 0, 0, 0, 0, 1);
    tick(); @(negedge clk); chk_out("vmul.c2", 0, 0, 0, 0, 1, 0, 0, 1);
    tick(); @(negedge clk); chk_out("vmul.c3", 0, 0, 0, 0, 1, 1, 0, 1);
    tick(); @(negedge clk); chk_out("vmul.c4", 0, 0, 0, 0, 0, 0, 1, 0);

    // masked sew=1 vl=8 with a two-cycle stall after beat 0
    tick(); offer(9'h000, 3'd1, 8'd8, 1'b1); bus.mask_slice = 8'b00001010;
    @(negedge clk); chk_out("msk.acc", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("msk.b0", 1, 0, 8'h0A, 1, 1, 0, 0, 1);
    tick(); bus.issue_stall = 1'b1;
    @(negedge clk); chk_out("msk.st0", 0, 0, 0, 0, 0, 0, 0, 1);
    tick(); @(negedge clk); chk_out("msk.st1", 0, 0, 0, 0, 0, 0, 0, 1);
    tick(); bus.issue_stall = 1'b0; bus.mask_slice = 8'b11111010;
    @(negedge clk); chk_out("msk.b1", 1, 1, 8'h0A, 1, 1, 1, 0, 1);
    tick(); bus.mask_slice = '0;
    @(negedge clk); chk_out("msk.end", 0, 0, 0, 0, 0, 0, 1, 0);

    // flush during beat 1 of a 4-beat vmulh
    tick(); offer(9'b010100111, 3'd3, 8'd4, 1'b0);
    @(negedge clk); chk_out("fl.acc", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("fl.b0", 1, 0, 8'h01, 0, 0, 0, 0, 1);
    tick(); bus.flush = 1'b1;
    @(negedge clk); chk_out("fl.b1", 1, 1, 8'h01, 0, 0, 0, 0, 1);
    tick(); bus.flush = 1'b0;
    @(negedge clk); chk_out("fl.c2", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); @(negedge clk); chk_out("fl.c3", 0, 0, 0, 0, 0, 0, 1, 0);

    // flush blocks an accept in IDLE
    tick(); offer(9'h000, 3'd0, 8'd8, 1'b0); bus.flush = 1'b1;
    @(negedge clk); chk_out("flacc.c0", 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); bus.flush = 1'b0; bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("flacc.c1", 0, 0, 0, 0, 0, 0, 1, 0);

    // vl=0 retires in the accept cycle
    tick(); offer(9'h000, 3'd0, 8'd0, 1'b0);
    @(negedge clk); chk_out("vl0.acc", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("vl0.c1", 0, 0, 0, 0, 0, 0, 1, 0);

    // reserved sew: accepted, nothing issued
    tick(); offer(9'b010100101, 3'd5, 8'd8, 1'b0);
    @(negedge clk); chk_out("rsv.acc", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("rsv.c1", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); @(negedge clk); chk_out("rsv.c2", 0, 0, 0, 0, 0, 0, 1, 0);

    // the other two multiply-class decodes, single beat each
    for (int n = 0; n < 2; n++) begin
      tick(); offer(mops[n], 3'd3, 8'd1, 1'b0);
      @(negedge clk); chk_out($sformatf("mdec%0d.acc", n), 0, 0, 0, 0, 0, 0, 1, 0);
      tick(); bus.instr_valid = 1'b0;
      @(negedge clk); chk_out($sformatf("mdec%0d.c0", n), 1, 0, 8'h01, 0, 0, 0, 0, 1);
      tick(); @(negedge clk); chk_out($sformatf("mdec%0d.c1", n), 0, 0, 0, 0, 0, 0, 0, 1);
      tick(); @(negedge clk); chk_out($sformatf("mdec%0d.c2", n), 0, 0, 0, 0, 1, 0, 0, 1);
      tick(); @(negedge clk); chk_out($sformatf("mdec%0d.c3", n), 0, 0, 0, 0, 0, 0, 1, 0);
    end

    // near-miss opcode is not multiply-class
    tick(); offer(9'b000101000, 3'd3, 8'd1, 1'b0);
    @(negedge clk); chk_out("nmul.acc", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("nmul.c0", 1, 0, 8'h01, 0, 1, 0, 0, 1);
    tick(); @(negedge clk); chk_out("nmul.c1", 0, 0, 0, 0, 0, 0, 1, 0);

    // reset pulse mid-ISSUE discards in-flight multiply beats
    tick(); offer(9'b010100101, 3'd3, 8'd4, 1'b0);
    @(negedge clk); chk_out("rmid.acc", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); bus.instr_valid = 1'b0;
    @(negedge clk); chk_out("rmid.b0", 1, 0, 8'h01, 0, 0, 0, 0, 1);
    tick(); rst = 1'b1;
    @(negedge clk); chk_out("rmid.rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rmid.rst.alu_op", bus.alu_op, 0);
    tick(); rst = 1'b0;
    @(negedge clk); chk_out("rmid.c2", 0, 0, 0, 0, 0, 0, 1, 0);
    chk("rmid.c2.alu_op", bus.alu_op, 0);
    chk("rmid.c2.alu_sew", bus.alu_sew, 0);
    tick(); @(negedge clk); chk_out("rmid.c3", 0, 0, 0, 0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
